// File: rtl/pid_update_scheduler.sv
// pid_update_scheduler
//
// Sequences the per-motor PID controllers. A loop-rate timer produces a
// control tick; on each tick the enabled motors are swept in ascending index
// order. For every motor a sensor sample is requested (sensor_req/sensor_ack),
// the motor's single-cycle update_controller strobe fires, and a settle gap
// follows so each PID's edge detector re-arms.
//
// Ports:
//   clock, reset_n     system clock, asynchronous active-low reset
//   enable             run scheduler; low aborts to IDLE
//   loop_period        clock cycles per control tick (values < 2 act as 2)
//   motor_mask         motors to update, sampled when a sweep starts
//   sensor_req         level request for a sample of motor sensor_motor
//   sensor_motor       index of the motor being serviced (held between uses)
//   sensor_ack         sample for sensor_motor is latched and valid
//   update_controller  one-hot single-cycle strobe to PID[i]
//   busy               sweep in progress (SELECT..DONE)
//   cycle_done         one-cycle pulse at sweep end
//   overrun_count      saturating count of ticks dropped while busy
//   timeout_flags      sticky per-motor sensor timeout flags
//
// Configuration macro: PID_SCHED_TIMEOUT_EN
//   Defined: REQ gives up after TIMEOUT_CYCLES cycles without an ack, sets the
//   motor's timeout flag, skips its strobe and continues the sweep.
//   Undefined: REQ waits indefinitely and timeout_flags is tied to 0.

module pid_update_scheduler #(
  parameter int NUM_MOTORS     = 6,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [31:0]           loop_period,
  input  logic [NUM_MOTORS-1:0] motor_mask,
  output logic                  sensor_req,
  output logic [3:0]            sensor_motor,
  input  logic                  sensor_ack,
  output logic [NUM_MOTORS-1:0] update_controller,
  output logic                  busy,
  output logic                  cycle_done,
  output logic [15:0]           overrun_count,
  output logic [NUM_MOTORS-1:0] timeout_flags
);

  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, SELECT, REQ, STROBE, SETTLE, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             tickCount_q, tickCount_d;
  logic [31:0]             periodEff, lastCount;
  logic                    tick;
  logic [NUM_MOTORS-1:0]   pend_q, pend_d;
  logic [3:0]              motor_q, motor_d;
  logic [SW-1:0]           settle_q, settle_d;
  logic [15:0]             overrun_q, overrun_d;
  logic [3:0]              selIdx;

`ifdef PID_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0]           wait_q, wait_d;
  logic [NUM_MOTORS-1:0]   flags_q, flags_d;
`endif

  // Tick timer. Using >= rather than == makes a shrunken loop_period wrap
  // immediately when the counter is already past the new terminal value.
  always_comb begin
    periodEff   = (loop_period < 32'd2) ? 32'd2 : loop_period;
    lastCount   = periodEff - 32'd1;
    tick        = enable && (tickCount_q >= lastCount);
    tickCount_d = tickCount_q + 32'd1;
    if (!enable || tick) begin
      tickCount_d = '0;
    end
  end

  // Lowest pending motor: scanning downward leaves the smallest index last.
  always_comb begin
    selIdx = '0;
    for (int i = NUM_MOTORS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        selIdx = 4'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    motor_d   = motor_q;
    settle_d  = settle_q;
    overrun_d = overrun_q;
`ifdef PID_SCHED_TIMEOUT_EN
    wait_d    = wait_q;
    flags_d   = flags_q;
`endif

    if (tick && (state_q != WAIT_TICK) && (overrun_q != 16'hFFFF)) begin
      overrun_d = overrun_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (tick) begin
          pend_d  = motor_mask;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (pend_q == '0) begin
          state_d = DONE;
        end else begin
          motor_d = selIdx;
          pend_d  = pend_q & ~(NUM_MOTORS'(1) << selIdx);
          state_d = REQ;
`ifdef PID_SCHED_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      REQ: begin
        if (sensor_ack) begin
          state_d = STROBE;
`ifdef PID_SCHED_TIMEOUT_EN
        end else if (wait_q == TW'(TIMEOUT_CYCLES - 1)) begin
          flags_d  = flags_q | (NUM_MOTORS'(1) << motor_q);
          settle_d = '0;
          state_d  = SETTLE;
        end else begin
          wait_d = wait_q + TW'(1);
`endif
        end
      end
      STROBE: begin
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d = SELECT;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      DONE: begin
        state_d = WAIT_TICK;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Disable overrides every transition, including an ack arriving in REQ.
    if (!enable) begin
      state_d = IDLE;
      pend_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tickCount_q <= '0;
      pend_q      <= '0;
      motor_q     <= '0;
      settle_q    <= '0;
      overrun_q   <= '0;
`ifdef PID_SCHED_TIMEOUT_EN
      wait_q      <= '0;
      flags_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tickCount_q <= tickCount_d;
      pend_q      <= pend_d;
      motor_q     <= motor_d;
      settle_q    <= settle_d;
      overrun_q   <= overrun_d;
`ifdef PID_SCHED_TIMEOUT_EN
      wait_q      <= wait_d;
      flags_q     <= flags_d;
`endif
    end
  end

  assign sensor_req        = (state_q == REQ);
  assign sensor_motor      = motor_q;
  assign update_controller = (state_q == STROBE) ? (NUM_MOTORS'(1) << motor_q) : '0;
  assign busy              = (state_q == SELECT) || (state_q == REQ) || (state_q == STROBE) ||
                             (state_q == SETTLE) || (state_q == DONE);
  assign cycle_done        = (state_q == DONE);
  assign overrun_count     = overrun_q;
`ifdef PID_SCHED_TIMEOUT_EN
  assign timeout_flags     = flags_q;
`else
  assign timeout_flags     = '0;
`endif

endmodule

// File: tb/tb_pid_update_scheduler.sv
// tb_pid_update_scheduler
//
// Self-checking bench for pid_update_scheduler (default parameters: 6 motors,
// settle gap of 2). A per-cycle vector table covers a two-motor sweep with an
// overrun and a mid-sweep mask change; hand-written sequences cover the empty
// mask with a clamped loop period, enable abort in REQ, the ack wait (with or
// without PID_SCHED_TIMEOUT_EN) and an asynchronous reset during STROBE.

module tb_pid_update_scheduler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] loop_period = 32'd8;
  logic [5:0]  motor_mask = '0;
  logic        sensor_req;
  logic [3:0]  sensor_motor;
  logic        sensor_ack = 1'b0;
  logic [5:0]  update_controller;
  logic        busy;
  logic        cycle_done;
  logic [15:0] overrun_count;
  logic [5:0]  timeout_flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic        ack;
    logic [5:0]  mask;
    logic        req;
    logic [3:0]  mot;
    logic [5:0]  uc;
    logic        busy;
    logic        done;
    logic [15:0] ovr;
  } vec_t;

  vec_t vecs[$];

  pid_update_scheduler dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .enable            (enable),
    .loop_period       (loop_period),
    .motor_mask        (motor_mask),
    .sensor_req        (sensor_req),
    .sensor_motor      (sensor_motor),
    .sensor_ack        (sensor_ack),
    .update_controller (update_controller),
    .busy              (busy),
    .cycle_done        (cycle_done),
    .overrun_count     (overrun_count),
    .timeout_flags     (timeout_flags)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] packOut();
    return {3'b000, sensor_req, sensor_motor, update_controller, busy, cycle_done, overrun_count};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic ack, input logic [5:0] mask);
    enable     = en;
    sensor_ack = ack;
    motor_mask = mask;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic addVec(input logic en, input logic ack, input logic [5:0] mask,
                        input logic req, input logic [3:0] mot, input logic [5:0] uc,
                        input logic bsy, input logic done, input logic [15:0] ovr);
    vecs.push_back('{en, ack, mask, req, mot, uc, bsy, done, ovr});
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 6'h00);
    reset_n = 1'b0;
    step();
    step();
    checkOutput("reset_outputs", packOut(), 32'h0);
    checkOutput("reset_flags", {26'd0, timeout_flags}, 32'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    int bad;
    int held;
    logic [15:0] savedOvr;
    logic [31:0] expPacked;
    logic        expBusy;
    logic        expDone;

    // Sweep of motors 0 and 2 with period 8; tick at vector 7, second tick
    // at vector 15 lands in REQ and is counted as an overrun.
    for (int i = 0; i < 7; i++) addVec(1, 0, 6'h05, 0, 0, 6'h00, 0, 0, 0);
    addVec(1, 0, 6'h05, 0, 0, 6'h00, 1, 0, 0);
    addVec(1, 0, 6'h3F, 1, 0, 6'h00, 1, 0, 0);
    addVec(1, 1, 6'h3F, 0, 0, 6'h01, 1, 0, 0);
    addVec(1, 0, 6'h3F, 0, 0, 6'h00, 1, 0, 0);
    addVec(1, 0, 6'h3F, 0, 0, 6'h00, 1, 0, 0);
    addVec(1, 1, 6'h3F, 0, 0, 6'h00, 1, 0, 0);
    addVec(1, 0, 6'h3F, 1, 2, 6'h00, 1, 0, 0);
    addVec(1, 0, 6'h3F, 1, 2, 6'h00, 1, 0, 0);
    addVec(1, 1, 6'h3F, 0, 2, 6'h04, 1, 0, 1);
    addVec(1, 0, 6'h3F, 0, 2, 6'h00, 1, 0, 1);
    addVec(1, 0, 6'h3F, 0, 2, 6'h00, 1, 0, 1);
    addVec(1, 0, 6'h3F, 0, 2, 6'h00, 1, 0, 1);
    addVec(1, 0, 6'h3F, 0, 2, 6'h00, 1, 1, 1);
    for (int i = 0; i < 3; i++) addVec(1, 0, 6'h05, 0, 2, 6'h00, 0, 0, 1);
    addVec(1, 0, 6'h05, 0, 2, 6'h00, 1, 0, 1);
    addVec(1, 0, 6'h05, 1, 0, 6'h00, 1, 0, 1);
    addVec(1, 1, 6'h05, 0, 0, 6'h01, 1, 0, 1);

    $display("[TB] table sweep");
    loop_period = 32'd8;
    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].en, vecs[i].ack, vecs[i].mask);
      step();
      expPacked = {3'b000, vecs[i].req, vecs[i].mot, vecs[i].uc, vecs[i].busy, vecs[i].done, vecs[i].ovr};
      checkOutput($sformatf("vec%0d", i), packOut(), expPacked);
    end

    // Empty mask with loop_period=1 (clamped to 2): SELECT, DONE, then the
    // next tick always falls in DONE and is dropped.
    $display("[TB] empty mask, clamped period");
    loop_period = 32'd1;
    doReset();
    applyStimulus(1'b1, 1'b0, 6'h00);
    for (int e = 0; e < 12; e++) begin
      step();
      expBusy = (e % 4 == 1) || (e % 4 == 2);
      expDone = (e % 4 == 2);
      expPacked = {3'b000, 1'b0, 4'd0, 6'h00, expBusy, expDone, 16'((e + 1) / 4)};
      checkOutput($sformatf("empty_e%0d", e), packOut(), expPacked);
    end

    // Motor 3 only, ack withheld.
    $display("[TB] ack wait and enable abort");
    loop_period = 32'd20;
    doReset();
    applyStimulus(1'b1, 1'b0, 6'h08);
    n = 0;
    while (!sensor_req && n < 40) begin
      step();
      n++;
    end
    checkOutput("req_latency", n, 21);
    checkOutput("req_motor", {28'd0, sensor_motor}, 32'd3);
`ifdef PID_SCHED_TIMEOUT_EN
    held = 1;
    bad = 0;
    while (sensor_req && held < 400) begin
      step();
      if (update_controller != 6'h00) bad++;
      if (sensor_req) held++;
    end
    checkOutput("timeout_req_cycles", held, 255);
    checkOutput("timeout_no_strobe", bad, 0);
    checkOutput("timeout_flag", {26'd0, timeout_flags}, 32'h08);
`else
    held = 0;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (!sensor_req || !busy || update_controller != 6'h00) bad++;
    end
    checkOutput("req_held", bad, 0);
    checkOutput("no_timeout_flags", {26'd0, timeout_flags}, 32'h0);
    checkOutput("ovr_while_req", {16'd0, overrun_count}, 32'd15);
`endif
    applyStimulus(1'b0, 1'b1, 6'h08);
    step();
    checkOutput("abort_req_busy", {30'd0, sensor_req, busy}, 32'h0);
    checkOutput("abort_no_strobe", {26'd0, update_controller}, 32'h0);
    step();
    checkOutput("abort_no_strobe2", {26'd0, update_controller}, 32'h0);
    savedOvr = overrun_count;
    checkOutput("ovr_nonzero", {31'd0, (savedOvr != 16'd0)}, 32'd1);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (busy || sensor_req) bad++;
    end
    checkOutput("disabled_idle", bad, 0);
    checkOutput("ovr_kept_disabled", {16'd0, overrun_count}, {16'd0, savedOvr});

    // Re-enable with ack always high: strobe only after the next tick.
    applyStimulus(1'b1, 1'b1, 6'h08);
    n = 0;
    while (update_controller == 6'h00 && n < 60) begin
      step();
      n++;
    end
    checkOutput("restart_latency", n, 22);
    checkOutput("restart_strobe", {26'd0, update_controller}, 32'h08);
    checkOutput("ovr_kept_restart", {16'd0, overrun_count}, {16'd0, savedOvr});

    // Asynchronous reset while the strobe is visible.
    $display("[TB] async reset in STROBE");
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", packOut(), 32'h0);
    checkOutput("async_reset_flags", {26'd0, timeout_flags}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    loop_period = 32'd4;
    applyStimulus(1'b1, 1'b1, 6'h02);
    n = 0;
    while (update_controller == 6'h00 && n < 20) begin
      step();
      n++;
    end
    checkOutput("post_reset_latency", n, 6);
    checkOutput("post_reset_strobe", packOut(), {3'b000, 1'b0, 4'd1, 6'h02, 1'b1, 1'b0, 16'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
